sccb_dual_cam_sequencer: RTL and testbench
==========================================

// Module: sccb_dual_cam_sequencer
// PURPOSE
//  Shares one SCCB write master between the left and right OV7670 cameras (replaces two free-running SCCB tops).
//  Walks a register ROM once for the left camera, then once for the right, steering the master via cam_sel.
//  Reports per-camera done/error to the top level, and restarts on command.
// PARAMETERS
//  NUM_REGS      76          ROM entries per pass (index 0..NUM_REGS-1)
//  IDX_W         7           rom_addr width; 2**IDX_W >= NUM_REGS
//  DEV_ID        8'h42       OV7670 SCCB write address
//  POWERUP_WAIT  100_000     clk cycles waited after reset before the first write
//  DELAY_CYCLES  100_000     clk cycles inserted for a ROM delay entry (reg byte 8'hFF)
//  MAX_RETRY     3           NACK retries per entry before that camera is flagged in error
// PORTS
//  clk          in   1      system clock
//  reset        in   1      synchronous, active-high reset
//  start        in   1      1-cycle pulse: reconfigure both cameras (honoured only in DONE)
//  rom_addr     out  IDX_W  ROM index; rom_data valid exactly 1 cycle later
//  rom_data     in   16     {reg[15:8], val[7:0]}; 16'hFFFF = end of table
//  sccb_req     out  1      1-cycle write request to the SCCB master
//  sccb_busy    in   1      master busy; sccb_req is issued only while low
//  sccb_done    in   1      1-cycle pulse: transaction finished
//  sccb_nack    in   1      NACK flag, valid only in the sccb_done cycle
//  sccb_dev     out  8      device address for the request
//  sccb_reg     out  8      register address for the request
//  sccb_val     out  8      register value for the request
//  cam_sel      out  1      0 = left (SDA_L/SCL_L), 1 = right (SDA_R/SCL_R)
//  cfg_busy     out  1      sequence in progress
//  cfg_done     out  2      [0] left, [1] right; set when the pass finishes without error
//  cfg_error    out  2      [0] left, [1] right; set when retries are exhausted
// BEHAVIOUR
//  Reset: all outputs 0, idx = 0, retry = 0, state -> PWR_WAIT. cfg_busy rises on the first cycle after reset.
//  States:
//   PWR_WAIT  count POWERUP_WAIT cycles -> FETCH.
//   FETCH     drive rom_addr = idx -> FWAIT.
//   FWAIT     capture rom_data:
//             16'hFFFF or idx == NUM_REGS -> SWITCH;
//             reg == 8'hFF -> DELAY;
//             else latch sccb_reg/sccb_val, sccb_dev = DEV_ID -> ISSUE.
//   ISSUE     when !sccb_busy: sccb_req = 1 for 1 cycle -> WAIT.
//   WAIT      on sccb_done & !nack: idx++, retry = 0 -> FETCH.
//             on sccb_done & nack & retry < MAX_RETRY: retry++ -> ISSUE (same data).
//             on sccb_done & nack & retry == MAX_RETRY: set cfg_error[cam_sel] -> SWITCH.
//   DELAY     count DELAY_CYCLES; idx++ -> FETCH.
//   SWITCH    set cfg_done[cam_sel] unless that camera errored.
//             If cam_sel == 0 and !sccb_busy: cam_sel = 1, idx = 0, retry = 0 -> FETCH.
//             If cam_sel == 1 -> DONE.
//   DONE      cfg_busy = 0; cam_sel held at 1.
//             On start: clear cfg_done/cfg_error, cam_sel = 0, idx = 0 -> FETCH (no power-up wait).
//  cam_sel changes only in SWITCH/DONE while sccb_busy is low; it never toggles between req and done.
//  sccb_dev/reg/val hold stable from ISSUE through the matching sccb_done.
//  start outside DONE is ignored. sccb_done outside WAIT is ignored.
//  idx saturates at NUM_REGS and does not wrap; reaching it ends the pass as an end marker does.
//  Latency: one ROM entry = 3 cycles + master time + 1 cycle.
//  Reset in any state aborts immediately. The master must be reset by the same signal.
//  cfg_busy = 1 in every state except DONE (0 during reset).
// TESTING (NUM_REGS=4, POWERUP_WAIT=16, DELAY_CYCLES=8, MAX_RETRY=3; master model done 5 cycles after req)
//  ROM {1280,1100,8C00,FFFF}, no NACK -> after 16 cycles, 3 reqs on cam_sel=0 then 3 on cam_sel=1,
//    sccb_dev=42; cfg_done=2'b11, cfg_error=0, cfg_busy=0.
//  ROM entry 1 = FF00 -> an 8-cycle gap with no sccb_req between entries 0 and 2, on each camera.
//  NACK every transfer while cam_sel=0 -> 4 reqs with identical reg/val, cfg_error=2'b01,
//    right camera still programmed, cfg_done=2'b10.
//  sccb_busy held high for 20 cycles in ISSUE -> sccb_req stays 0 until busy falls, then exactly 1 pulse.
//  Reset asserted mid-WAIT on the right camera -> next cycle all outputs 0,
//    the sequence restarts from PWR_WAIT with cam_sel=0.
//  start in DONE -> cfg_done cleared next cycle, full L then R pass, no power-up wait;
//    start during a pass -> no effect.

Source files
------------

// File: rtl/sccb_dual_cam_sequencer.sv
// -----------------------------------------------------------------------------
// sccb_dual_cam_sequencer
//
// Shares one SCCB write master between the left and right OV7670 cameras.
// After power-up it walks the register ROM once with cam_sel = 0 (left), then
// once with cam_sel = 1 (right), and reports per-camera done/error.
// A start pulse in DONE reruns both passes without the power-up wait.
//
// Ports
//   clk, reset          system clock, synchronous active-high reset
//   start               1-cycle restart pulse, honoured only in DONE
//   rom_addr            ROM index; rom_data is expected one cycle later
//   rom_data            {reg, val}; 16'hFFFF ends the table, reg 8'hFF = delay
//   sccb_req            1-cycle write request to the shared master
//   sccb_busy           master busy; no request is issued while high
//   sccb_done/nack      transaction complete pulse and its NACK flag
//   sccb_dev/reg/val    request payload, stable from ISSUE until sccb_done
//   cam_sel             0 = left bus, 1 = right bus
//   cfg_busy            sequence in progress (low only in DONE and reset)
//   cfg_done/cfg_error  [0] left, [1] right pass result
// -----------------------------------------------------------------------------
module sccb_dual_cam_sequencer #(
    parameter int         NUM_REGS     = 76,
    parameter int         IDX_W        = 7,
    parameter logic [7:0] DEV_ID       = 8'h42,
    parameter int         POWERUP_WAIT = 100_000,
    parameter int         DELAY_CYCLES = 100_000,
    parameter int         MAX_RETRY    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [IDX_W-1:0] rom_addr,
    input  logic [15:0]      rom_data,
    output logic             sccb_req,
    input  logic             sccb_busy,
    input  logic             sccb_done,
    input  logic             sccb_nack,
    output logic [7:0]       sccb_dev,
    output logic [7:0]       sccb_reg,
    output logic [7:0]       sccb_val,
    output logic             cam_sel,
    output logic             cfg_busy,
    output logic [1:0]       cfg_done,
    output logic [1:0]       cfg_error
);

    typedef enum logic [2:0] {
        ST_PWR_WAIT,
        ST_FETCH,
        ST_FWAIT,
        ST_ISSUE,
        ST_WAIT,
        ST_DELAY,
        ST_SWITCH,
        ST_DONE
    } state_t;

    localparam int CNT_MAX = (POWERUP_WAIT > DELAY_CYCLES) ? POWERUP_WAIT : DELAY_CYCLES;
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
    localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [CNT_W-1:0]   PWR_LAST  = CNT_W'(POWERUP_WAIT - 1);
    localparam logic [CNT_W-1:0]   DLY_LAST  = CNT_W'(DELAY_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(MAX_RETRY);
    // idx carries one extra bit so it can hold NUM_REGS itself even when
    // 2**IDX_W == NUM_REGS; the saturated value terminates the pass.
    localparam logic [IDX_W:0]     END_IDX   = (IDX_W + 1)'(NUM_REGS);

    state_t               state;
    logic [IDX_W:0]       idx;
    logic [RETRY_W-1:0]   retry;
    logic [CNT_W-1:0]     cnt;

    // The ROM is synchronous: the address is already stable during FETCH
    // because it follows idx directly, so rom_data is valid for FWAIT.
    assign rom_addr = idx[IDX_W-1:0];

    // NOTE: all state and outputs are flops updated with <=, so every branch
    // reads the values from before this edge regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_PWR_WAIT;
            idx       <= '0;
            retry     <= '0;
            cnt       <= '0;
            sccb_req  <= 1'b0;
            sccb_dev  <= '0;
            sccb_reg  <= '0;
            sccb_val  <= '0;
            cam_sel   <= 1'b0;
            cfg_busy  <= 1'b0;
            cfg_done  <= '0;
            cfg_error <= '0;
        end else begin
            // Request is a single-cycle pulse; only ISSUE raises it.
            sccb_req <= 1'b0;

            case (state)
                ST_PWR_WAIT: begin
                    cfg_busy <= 1'b1;
                    if (cnt == PWR_LAST) begin
                        cnt   <= '0;
                        state <= ST_FETCH;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_FETCH: state <= ST_FWAIT;

                ST_FWAIT: begin
                    if (idx == END_IDX || rom_data == 16'hFFFF) begin
                        state <= ST_SWITCH;
                    end else if (rom_data[15:8] == 8'hFF) begin
                        state <= ST_DELAY;
                    end else begin
                        sccb_dev <= DEV_ID;
                        sccb_reg <= rom_data[15:8];
                        sccb_val <= rom_data[7:0];
                        state    <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    if (!sccb_busy) begin
                        sccb_req <= 1'b1;
                        state    <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (sccb_done) begin
                        if (!sccb_nack) begin
                            if (idx != END_IDX) idx <= idx + 1'b1;
                            retry <= '0;
                            state <= ST_FETCH;
                        end else if (retry < RETRY_LIM) begin
                            // Payload registers are untouched, so the retry
                            // resends the same reg/val.
                            retry <= retry + 1'b1;
                            state <= ST_ISSUE;
                        end else begin
                            cfg_error[cam_sel] <= 1'b1;
                            state              <= ST_SWITCH;
                        end
                    end
                end

                ST_DELAY: begin
                    if (cnt == DLY_LAST) begin
                        cnt <= '0;
                        if (idx != END_IDX) idx <= idx + 1'b1;
                        state <= ST_FETCH;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_SWITCH: begin
                    if (!cfg_error[cam_sel]) cfg_done[cam_sel] <= 1'b1;
                    if (cam_sel) begin
                        cfg_busy <= 1'b0;
                        state    <= ST_DONE;
                    end else if (!sccb_busy) begin
                        // Bus swap only while the master is idle, so no
                        // transaction ever straddles a cam_sel change.
                        cam_sel <= 1'b1;
                        idx     <= '0;
                        retry   <= '0;
                        state   <= ST_FETCH;
                    end
                end

                ST_DONE: begin
                    if (start && !sccb_busy) begin
                        cfg_done  <= '0;
                        cfg_error <= '0;
                        cam_sel   <= 1'b0;
                        idx       <= '0;
                        retry     <= '0;
                        cfg_busy  <= 1'b1;
                        state     <= ST_FETCH;
                    end
                end

                default: state <= ST_PWR_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_sccb_dual_cam_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sccb_dual_cam_sequencer
//
// Directed bench for the dual-camera SCCB sequencer with a small ROM, a
// synchronous ROM model and a fixed-latency SCCB master model (done pulse
// five cycles after each request). Expected requests are queued when a test
// is set up; a monitor pops and compares on every sccb_req.
// -----------------------------------------------------------------------------
module tb_sccb_dual_cam_sequencer;

    localparam int NUM_REGS     = 4;
    localparam int IDX_W        = 3;
    localparam int POWERUP_WAIT = 16;
    localparam int DELAY_CYCLES = 8;
    localparam int MAX_RETRY    = 3;

    typedef logic [24:0] req_t;  // {cam, dev, reg, val}

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [IDX_W-1:0] rom_addr;
    logic [15:0]      rom_data = 16'h0000;
    logic             sccb_req;
    logic             sccb_busy;
    logic             sccb_done;
    logic             sccb_nack;
    logic [7:0]       sccb_dev;
    logic [7:0]       sccb_reg;
    logic [7:0]       sccb_val;
    logic             cam_sel;
    logic             cfg_busy;
    logic [1:0]       cfg_done;
    logic [1:0]       cfg_error;

    int n_vectors     = 0;
    int n_miscompares = 0;

    sccb_dual_cam_sequencer #(
        .NUM_REGS    (NUM_REGS),
        .IDX_W       (IDX_W),
        .DEV_ID      (8'h42),
        .POWERUP_WAIT(POWERUP_WAIT),
        .DELAY_CYCLES(DELAY_CYCLES),
        .MAX_RETRY   (MAX_RETRY)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .sccb_req (sccb_req),
        .sccb_busy(sccb_busy),
        .sccb_done(sccb_done),
        .sccb_nack(sccb_nack),
        .sccb_dev (sccb_dev),
        .sccb_reg (sccb_reg),
        .sccb_val (sccb_val),
        .cam_sel  (cam_sel),
        .cfg_busy (cfg_busy),
        .cfg_done (cfg_done),
        .cfg_error(cfg_error)
    );

    always #5 clk = ~clk;

    // ---------------- ROM model (registered read) ----------------
    logic [15:0] rom [8];
    always @(posedge clk) rom_data <= rom[rom_addr];

    // ---------------- SCCB master model ----------------
    logic m_busy = 1'b0;
    int   m_cnt  = 0;
    logic busy_hold = 1'b0;
    logic nack_left = 1'b0;
    initial begin
        sccb_done = 1'b0;
        sccb_nack = 1'b0;
    end
    assign sccb_busy = m_busy | busy_hold;

    always @(posedge clk) begin
        if (reset) begin
            m_busy    <= 1'b0;
            m_cnt     <= 0;
            sccb_done <= 1'b0;
            sccb_nack <= 1'b0;
        end else begin
            sccb_done <= 1'b0;
            sccb_nack <= 1'b0;
            if (m_busy) begin
                if (m_cnt == 0) begin
                    m_busy    <= 1'b0;
                    sccb_done <= 1'b1;
                    sccb_nack <= nack_left && !cam_sel;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end else if (sccb_req) begin
                m_busy <= 1'b1;
                m_cnt  <= 3;
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    req_t exp_q[$];
    int   req_cyc[$];
    req_t last_req = '0;
    int   cyc = 0;
    logic busy_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        req_t got;
        req_t exp_r;
        if (!reset) begin
            if (sccb_req) begin
                got = {cam_sel, sccb_dev, sccb_reg, sccb_val};
                n_vectors++;
                if (exp_q.size() == 0) begin
                    n_miscompares++;
                    $display("FAIL req_unexpected: got %h, required no request", got);
                end else begin
                    exp_r = exp_q.pop_front();
                    if (got !== exp_r) begin
                        n_miscompares++;
                        $display("FAIL req_payload: got %h, required %h", got, exp_r);
                    end
                end
                n_vectors++;
                if (busy_prev !== 1'b0) begin
                    n_miscompares++;
                    $display("FAIL req_while_busy: busy was %b, required 0", busy_prev);
                end
                last_req = got;
                req_cyc.push_back(cyc);
            end
            if (sccb_done) begin
                got = {cam_sel, sccb_dev, sccb_reg, sccb_val};
                n_vectors++;
                if (got !== last_req) begin
                    n_miscompares++;
                    $display("FAIL hold_stable: got %h at done, required %h", got, last_req);
                end
            end
        end
        busy_prev = sccb_busy;
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp_v);
        n_vectors++;
        if (got !== exp_v) begin
            n_miscompares++;
            $display("FAIL %s: got %h, required %h", name, got, exp_v);
        end
    endtask

    task automatic load_rom(input logic [15:0] e0, input logic [15:0] e1,
                            input logic [15:0] e2, input logic [15:0] e3);
        rom[0] = e0;
        rom[1] = e1;
        rom[2] = e2;
        rom[3] = e3;
        for (int i = 4; i < 8; i++) rom[i] = 16'h1234;
    endtask

    task automatic push_exp(input logic cam, input logic [7:0] rg, input logic [7:0] val);
        exp_q.push_back({cam, 8'h42, rg, val});
    endtask

    task automatic push_std();
        for (int c = 0; c < 2; c++) begin
            push_exp(c[0], 8'h12, 8'h80);
            push_exp(c[0], 8'h11, 8'h00);
            push_exp(c[0], 8'h8C, 8'h00);
        end
    endtask

    task automatic enter_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    logic busy_first;
    // Counts clock edges from now until sccb_req is seen; drops busy_hold
    // after edge hold_until (0 = no hold).
    task automatic wait_first_req(input int hold_until, output int n);
        n = 0;
        while (1) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) busy_first = cfg_busy;
            if (n == hold_until) busy_hold = 1'b0;
            if (sccb_req || n >= 200) break;
        end
    endtask

    task automatic wait_idle(input string tag, input logic [1:0] exp_done, input logic [1:0] exp_err);
        logic timed_out;
        timed_out = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            if (!cfg_busy) begin
                timed_out = 1'b0;
                break;
            end
        end
        check({tag, "_timeout"}, {31'd0, timed_out}, 32'd0);
        check({tag, "_cfg_done"}, {30'd0, cfg_done}, {30'd0, exp_done});
        check({tag, "_cfg_error"}, {30'd0, cfg_error}, {30'd0, exp_err});
        check({tag, "_cam_sel"}, {31'd0, cam_sel}, 32'd1);
        check({tag, "_pending"}, exp_q.size(), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        logic found;

        load_rom(16'h1280, 16'h1100, 16'h8C00, 16'hFFFF);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs",
              {rom_addr, sccb_req, sccb_dev, sccb_reg, sccb_val, cam_sel, cfg_busy, cfg_done, cfg_error},
              32'd0);

        // A: plain table, both cameras
        push_std();
        req_cyc.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        wait_first_req(0, n);
        check("A_busy_after_reset", {31'd0, busy_first}, 32'd1);
        check("A_first_req_latency", n, 32'd19);
        wait_idle("A", 2'b11, 2'b00);
        check("A_entry_spacing_L", req_cyc[1] - req_cyc[0], 32'd9);
        check("A_entry_spacing_R", req_cyc[4] - req_cyc[3], 32'd9);

        // B: delay entry between entries 0 and 2
        enter_reset();
        load_rom(16'h1280, 16'hFF00, 16'h8C00, 16'hFFFF);
        for (int c = 0; c < 2; c++) begin
            push_exp(c[0], 8'h12, 8'h80);
            push_exp(c[0], 8'h8C, 8'h00);
        end
        req_cyc.delete();
        reset = 1'b0;
        wait_first_req(0, n);
        check("B_first_req_latency", n, 32'd19);
        wait_idle("B", 2'b11, 2'b00);
        check("B_delay_spacing_L", req_cyc[1] - req_cyc[0], 32'd19);
        check("B_delay_spacing_R", req_cyc[3] - req_cyc[2], 32'd19);

        // C: busy held for 20 cycles while sitting in ISSUE
        enter_reset();
        load_rom(16'h1280, 16'h1100, 16'h8C00, 16'hFFFF);
        push_std();
        busy_hold = 1'b1;
        reset = 1'b0;
        wait_first_req(38, n);
        check("C_req_after_busy_falls", n, 32'd39);
        wait_idle("C", 2'b11, 2'b00);

        // D: left camera NACKs everything
        enter_reset();
        nack_left = 1'b1;
        for (int i = 0; i < 4; i++) push_exp(1'b0, 8'h12, 8'h80);
        push_exp(1'b1, 8'h12, 8'h80);
        push_exp(1'b1, 8'h11, 8'h00);
        push_exp(1'b1, 8'h8C, 8'h00);
        reset = 1'b0;
        wait_idle("D", 2'b10, 2'b01);
        nack_left = 1'b0;

        // F: start in DONE, then start during the pass is ignored
        push_std();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("F_done_cleared", {30'd0, cfg_done}, 32'd0);
        check("F_error_cleared", {30'd0, cfg_error}, 32'd0);
        check("F_busy_restart", {31'd0, cfg_busy}, 32'd1);
        wait_first_req(0, n);
        check("F_no_powerup_wait", n, 32'd3);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_idle("F", 2'b11, 2'b00);

        // E: reset in WAIT on the right camera
        enter_reset();
        push_std();
        reset = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk);
            #1;
            if (sccb_req && cam_sel) begin
                found = 1'b1;
                break;
            end
        end
        check("E_reached_right", {31'd0, found}, 32'd1);
        @(posedge clk);
        #1 reset = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        check("E_reset_outputs",
              {rom_addr, sccb_req, sccb_dev, sccb_reg, sccb_val, cam_sel, cfg_busy, cfg_done, cfg_error},
              32'd0);
        push_std();
        reset = 1'b0;
        wait_first_req(0, n);
        check("E_restart_latency", n, 32'd19);
        wait_idle("E", 2'b11, 2'b00);

        // G: no end marker, pass ends when idx reaches NUM_REGS
        load_rom(16'h1280, 16'h1100, 16'h8C00, 16'h3A04);
        for (int c = 0; c < 2; c++) begin
            push_exp(c[0], 8'h12, 8'h80);
            push_exp(c[0], 8'h11, 8'h00);
            push_exp(c[0], 8'h8C, 8'h00);
            push_exp(c[0], 8'h3A, 8'h04);
        end
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_idle("G", 2'b11, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
